// File: rtl/imem_arbiter_pkg.sv
// Shared types for the instruction SRAM arbiter: request/response bundles,
// response owner encoding and the SRAM geometry.
package imem_arbiter_pkg;

   localparam int IMEM_DEPTH      = 1024;
   localparam int IMEM_MAX_STARVE = 4;

   typedef struct packed {
      logic [63:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } imem_req_t;

   typedef struct packed {
      logic        rvalid;
      logic [31:0] rdata;
      logic        err;
   } imem_resp_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_I,
      OWN_L,
      OWN_LERR
   } imem_owner_e;

   function automatic logic in_range(input logic [63:0] addr,
                                     input int          depth);
      return addr < (64'(depth) << 2);
   endfunction

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Counts consecutive denied fetch cycles and raises force_i once the
// fetch port has waited MAX_STARVE cycles in a row.
module imem_arb_starve_ctr
   import imem_arbiter_pkg::*;
#(
   parameter int MAX_STARVE = IMEM_MAX_STARVE
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic gnt,
   output logic force_i
);

   localparam int W = $clog2(MAX_STARVE + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (~req | gnt) begin
         cnt <= '0;
      end else if (cnt != W'(MAX_STARVE)) begin
         cnt <= cnt + W'(1);
      end
   end

   assign force_i = (cnt == W'(MAX_STARVE));

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction SRAM arbiter: L has priority, I is guarded against
// starvation. Optional counters when IMEM_ARB_PERF_EN is defined.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int DEPTH      = IMEM_DEPTH,
   parameter int MAX_STARVE = IMEM_MAX_STARVE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [63:0] i_addr,
   input  logic        i_flush,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   input  logic        l_req,
   input  logic [63:0] l_addr,
   input  logic [3:0]  l_wstrb,
   input  logic [31:0] l_wdata,
   output logic        l_gnt,
   output logic        l_rvalid,
   output logic [31:0] l_rdata,
   output logic        l_err,
`ifdef IMEM_ARB_PERF_EN
   output logic [31:0] perf_i_stall,
   output logic [31:0] perf_l_err,
`endif
   output logic [63:0] sram_addr,
   output logic        sram_en,
   output logic [3:0]  sram_we,
   output logic [31:0] sram_din,
   input  logic [31:0] sram_dout
);

   logic        force_i;
   logic        l_ok;
   logic        l_write_q;
   imem_req_t   win;
   imem_resp_t  l_resp;
   imem_owner_e state;
   imem_owner_e state_nxt;

   imem_arb_starve_ctr #(
      .MAX_STARVE(MAX_STARVE)
   ) u_starve (
      .clk    (clk),
      .rst    (rst),
      .req    (i_req),
      .gnt    (i_gnt),
      .force_i(force_i)
   );

   assign l_ok  = in_range(l_addr, DEPTH);
   assign l_gnt = l_req & ~(force_i & i_req);
   assign i_gnt = i_req & ~l_gnt;

   always_comb begin
      win = '0;
      if (l_gnt) begin
         win = '{addr: l_addr, wstrb: l_wstrb, wdata: l_wdata};
      end else if (i_gnt) begin
         win.addr = i_addr;
      end
   end

   // Out-of-range L is granted but never touches the SRAM.
   assign sram_en   = i_gnt | (l_gnt & l_ok);
   assign sram_addr = win.addr;
   assign sram_din  = win.wdata;
   assign sram_we   = sram_en ? win.wstrb : 4'b0000;

   always_comb begin
      state_nxt = OWN_NONE;
      if (i_gnt) begin
         state_nxt = OWN_I;
      end else if (l_gnt) begin
         state_nxt = l_ok ? OWN_L : OWN_LERR;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= OWN_NONE;
         l_write_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         l_write_q <= l_gnt & (|l_wstrb);
      end
   end

   always_comb begin
      i_rvalid = 1'b0;
      i_rdata  = '0;
      l_resp   = '0;
      unique case (state)
         OWN_I: begin
            i_rvalid = ~i_flush;
            i_rdata  = sram_dout;
         end
         OWN_L: begin
            l_resp.rvalid = 1'b1;
            l_resp.rdata  = l_write_q ? 32'h0 : sram_dout;
         end
         OWN_LERR: begin
            l_resp.rvalid = 1'b1;
            l_resp.err    = 1'b1;
         end
         default: ;
      endcase
   end

   assign {l_rvalid, l_rdata, l_err} = l_resp;

`ifdef IMEM_ARB_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_i_stall <= '0;
         perf_l_err   <= '0;
      end else begin
         if (i_req & ~i_gnt) perf_i_stall <= perf_i_stall + 32'd1;
         if (state == OWN_LERR) perf_l_err <= perf_l_err + 32'd1;
      end
   end
`else
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized and directed bench for imem_arbiter against a transaction-level
// model (word array plus one expected response per grant).
module tb_imem_arbiter;
   import imem_arbiter_pkg::*;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [63:0] i_addr = '0;
   logic        i_flush = 1'b0;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        l_req = 1'b0;
   logic [63:0] l_addr = '0;
   logic [3:0]  l_wstrb = '0;
   logic [31:0] l_wdata = '0;
   logic        l_gnt;
   logic        l_rvalid;
   logic [31:0] l_rdata;
   logic        l_err;
`ifdef IMEM_ARB_PERF_EN
   logic [31:0] perf_i_stall;
   logic [31:0] perf_l_err;
`endif
   logic [63:0] sram_addr;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [31:0] sram_din;
   logic [31:0] sram_dout = '0;

   always #5 clk = ~clk;

   imem_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .i_req       (i_req),
      .i_addr      (i_addr),
      .i_flush     (i_flush),
      .i_gnt       (i_gnt),
      .i_rvalid    (i_rvalid),
      .i_rdata     (i_rdata),
      .l_req       (l_req),
      .l_addr      (l_addr),
      .l_wstrb     (l_wstrb),
      .l_wdata     (l_wdata),
      .l_gnt       (l_gnt),
      .l_rvalid    (l_rvalid),
      .l_rdata     (l_rdata),
      .l_err       (l_err),
`ifdef IMEM_ARB_PERF_EN
      .perf_i_stall(perf_i_stall),
      .perf_l_err  (perf_l_err),
`endif
      .sram_addr   (sram_addr),
      .sram_en     (sram_en),
      .sram_we     (sram_we),
      .sram_din    (sram_din),
      .sram_dout   (sram_dout)
   );

   // SRAM macro stand-in: 1-cycle synchronous read, byte write enables.
   logic [31:0] sram_mem [DEPTH];

   always @(posedge clk) begin
      if (sram_en) begin
         sram_dout <= sram_mem[sram_addr[11:2]];
         for (int b = 0; b < 4; b++)
            if (sram_we[b])
               sram_mem[sram_addr[11:2]][8*b +: 8] <= sram_din[8*b +: 8];
      end
   end

   // Reference model state.
   logic [31:0] ref_mem [DEPTH];
   int          pend_port;
   logic [31:0] pend_data;
   int          starve;
   int          exp_stall;
   int          exp_err;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_perf();
`ifdef IMEM_ARB_PERF_EN
      chk("perf_i_stall", 64'(perf_i_stall), 64'(32'(exp_stall)));
      chk("perf_l_err", 64'(perf_l_err), 64'(32'(exp_err)));
`endif
   endtask

   task automatic do_reset();
      i_req   = 1'b0;
      l_req   = 1'b0;
      i_flush = 1'b0;
      rst     = 1'b1;
      #1;
      pend_port = 0;
      starve    = 0;
      exp_stall = 0;
      exp_err   = 0;
      chk("rst_i_rvalid", 64'(i_rvalid), 64'(0));
      chk("rst_i_rdata", 64'(i_rdata), 64'(0));
      chk("rst_l_rvalid", 64'(l_rvalid), 64'(0));
      chk("rst_l_err", 64'(l_err), 64'(0));
      chk("rst_l_rdata", 64'(l_rdata), 64'(0));
      chk_perf();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One clock: drive at the falling edge, check just after, advance model.
   task automatic cycle(input logic ir, input logic [63:0] ia,
                        input logic fl, input logic lr,
                        input logic [63:0] la, input logic [3:0] ls,
                        input logic [31:0] ld);
      bit          force_i, eg_l, eg_i, ok, i_vis;
      int          nport;
      int          idx;
      logic [31:0] ndata;
      i_req   = ir;
      i_addr  = ia;
      i_flush = fl;
      l_req   = lr;
      l_addr  = la;
      l_wstrb = ls;
      l_wdata = ld;
      #1;
      force_i = (starve >= 4);
      eg_l    = lr && !(force_i && ir);
      eg_i    = ir && !eg_l;
      ok      = (la < 64'(DEPTH * 4));
      chk("l_gnt", 64'(l_gnt), 64'(eg_l));
      chk("i_gnt", 64'(i_gnt), 64'(eg_i));
      chk("sram_en", 64'(sram_en), 64'(eg_i || (eg_l && ok)));
      chk("sram_we", 64'(sram_we), 64'((eg_l && ok) ? ls : 4'b0));
      if (eg_i) chk("sram_addr_i", sram_addr, ia);
      if (eg_l && ok) chk("sram_addr_l", sram_addr, la);
      if (eg_l && ok && ls != 0) chk("sram_din", 64'(sram_din), 64'(ld));
      i_vis = (pend_port == 1) && !fl;
      chk("i_rvalid", 64'(i_rvalid), 64'(i_vis));
      if (i_vis) chk("i_rdata", 64'(i_rdata), 64'(pend_data));
      chk("l_rvalid", 64'(l_rvalid), 64'(pend_port >= 2));
      chk("l_err", 64'(l_err), 64'(pend_port == 3));
      if (pend_port >= 2) chk("l_rdata", 64'(l_rdata), 64'(pend_data));
      if (pend_port == 3) exp_err++;
      nport = 0;
      ndata = '0;
      if (eg_i) begin
         nport = 1;
         ndata = ref_mem[(ia >> 2) % DEPTH];
      end else if (eg_l && !ok) begin
         nport = 3;
      end else if (eg_l) begin
         nport = 2;
         idx   = int'(la >> 2);
         if (ls == 4'b0) begin
            ndata = ref_mem[idx];
         end else begin
            for (int b = 0; b < 4; b++)
               if (ls[b]) ref_mem[idx][8*b +: 8] = ld[8*b +: 8];
         end
      end
      if (ir && !eg_i) begin
         exp_stall++;
         starve = (starve < 4) ? starve + 1 : 4;
      end else begin
         starve = 0;
      end
      pend_port = nport;
      pend_data = ndata;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      cycle(0, 64'h0, 0, 0, 64'h0, 4'h0, 32'h0);
   endtask

   initial begin
      logic [63:0] ra, la;
      for (int k = 0; k < DEPTH; k++) begin
         sram_mem[k] = 32'(k);
         ref_mem[k]  = 32'(k);
      end
      @(negedge clk);
      do_reset();

      // back-to-back fetches of words 0..2
      cycle(1, 64'h0, 0, 0, 64'h0, 4'h0, 32'h0);
      cycle(1, 64'h4, 0, 0, 64'h0, 4'h0, 32'h0);
      cycle(1, 64'h8, 0, 0, 64'h0, 4'h0, 32'h0);
      idle();

      // L held against I: four L grants, fifth cycle forced to I
      for (int n = 0; n < 7; n++)
         cycle(1, 64'h40, 0, 1, 64'(n * 4), 4'h0, 32'h0);
      idle();

      // partial write then read back
      cycle(0, 64'h0, 0, 1, 64'h10, 4'b0011, 32'hDEADBEEF);
      cycle(0, 64'h0, 0, 1, 64'h10, 4'b0000, 32'h0);
      idle();

      // out-of-range L, and a wrapping I fetch
      cycle(0, 64'h0, 0, 1, 64'h1000, 4'h0, 32'h0);
      cycle(1, 64'h100C, 0, 0, 64'h0, 4'h0, 32'h0);
      cycle(0, 64'h0, 0, 1, 64'hFFFF_0000_0000_0004, 4'hF, 32'h1);
      idle();

      // flush in the response cycle, new fetch in the same cycle
      cycle(1, 64'h20, 0, 0, 64'h0, 4'h0, 32'h0);
      cycle(1, 64'h24, 1, 0, 64'h0, 4'h0, 32'h0);
      idle();

      // reset between grant and response
      cycle(1, 64'h30, 0, 0, 64'h0, 4'h0, 32'h0);
      do_reset();
      idle();
      cycle(0, 64'h0, 0, 1, 64'h2000, 4'h0, 32'h0);
      do_reset();
      idle();

      for (int n = 0; n < 3000; n++) begin
         ra = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
                                          : 64'($urandom_range(0, 4095));
         la = ($urandom_range(0, 7) == 0)
              ? 64'h1000 + 64'($urandom_range(0, 65535))
              : 64'($urandom_range(0, 4095));
         cycle(1'($urandom_range(0, 9) < 6), ra,
               1'($urandom_range(0, 9) < 2),
               1'($urandom_range(0, 1)), la,
               ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
               $urandom);
         if (n == 1500) do_reset();
      end
      idle();
      chk_perf();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
